clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//  Mode/sequencing controller for the alarm-clock digit counters. Drives en and up/down to the time
//  and alarm hour/minute counter chains: advances time in RUN, edits one field at a time in SET
//  modes, and raises the alarm ring on a time==alarm match. Sits between the debounced buttons and
//  the counter chains.
// PARAMETERS
//  RING_SECS  60  seconds ring stays on without user action (1..2^SEC_W-1)
//  IDLE_SECS  30  seconds without any button in a SET state before auto-return to RUN
//  SEC_W      6   width of internal second counters
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-low
//  tick_1hz   in   1   one-cycle pulse per second
//  tick_min   in   1   one-cycle pulse per minute (from seconds chain)
//  min_wrap   in   1   time minute chain at 59 (level, sampled with tick_min)
//  btn_c/l/r/u/d in 1 each  debounced one-cycle button pulses (centre/left/right/up/down)
//  alarm_sw   in   1   alarm armed (level)
//  time_hhmm  in   16  current time, BCD {hr_t,hr_u,min_t,min_u}
//  alm_hhmm   in   16  alarm time, BCD, same packing
//  t_min_en, t_hr_en, a_min_en, a_hr_en  out 1 each  counter enables (one-cycle pulses)
//  up_dn      out  1   direction for all enables: 1=up, 0=down
//  mode       out  3   current state encoding (below)
//  blink      out  1   selected-field blink, toggles on tick_1hz in SET states, 0 in RUN
//  ring       out  1   alarm ringing
// BEHAVIOUR
//  - All outputs registered. Reset (rst==0 at clk edge): state RUN, all en 0, up_dn 1, blink 0,
//    ring 0, idle/ring counters 0, match history 0. Reset wins over every other input.
//  - States (mode): RUN=0, SET_T_HR=1, SET_T_MIN=2, SET_A_HR=3, SET_A_MIN=4. 5..7 unreachable,
//    recover to RUN next cycle.
//  - RUN: btn_c -> SET_T_HR. tick_min -> t_min_en=1, up_dn=1 next cycle; additionally t_hr_en=1
//    in that same cycle if min_wrap was 1 with tick_min. Other buttons ignored (except ring clear).
//  - SET states: btn_r steps forward T_HR->T_MIN->A_HR->A_MIN->T_HR (wraps); btn_l steps reverse;
//    btn_c -> RUN. tick_min ignored (time frozen while editing).
//  - In SET: btn_u -> one-cycle en on the selected counter next cycle with up_dn=1; btn_d same
//    with up_dn=0. btn_u and btn_d together: no en. Navigation button in same cycle as u/d: the
//    en applies to the field selected before the transition.
//  - Button priority within a cycle: c > r > l for state change.
//  - Idle timeout: counter clears on any button; increments on tick_1hz in SET; reaching
//    IDLE_SECS -> RUN next cycle, counter cleared. Entering RUN clears blink.
//  - Alarm: match = (time_hhmm==alm_hhmm). ring set the cycle after match rises 0->1 while
//    state==RUN and alarm_sw==1. Match still high at SET->RUN exit does not retrigger.
//  - Ring clear (next cycle): any button pulse (pulse consumed, no mode change/en that cycle),
//    alarm_sw==0, or RING_SECS tick_1hz pulses counted since set. Set and clear same cycle: clear.
//  - At most one of t_min_en/a_min_en/a_hr_en high per cycle; t_hr_en may coincide with t_min_en
//    only in RUN rollover.
// TESTING
//  1. rst=0 two cycles with all inputs active -> all outputs 0 except up_dn=1, mode=0.
//  2. RUN, tick_min with min_wrap=1 -> next cycle t_min_en=1, t_hr_en=1, up_dn=1; min_wrap=0 -> only t_min_en.
//  3. btn_c, btn_r x3 -> mode 1,2,3,4; btn_r -> 1; btn_l -> 4; btn_d in mode 4 -> a_min_en=1, up_dn=0.
//  4. mode 2, tick_min pulses -> no t_min_en; 30 tick_1hz with no buttons -> mode=0.
//  5. alarm_sw=1, time_hhmm 16'h0659->16'h0700, alm_hhmm=16'h0700 -> ring=1 next cycle; 60 tick_1hz -> ring=0.
//  6. ring=1, btn_c -> ring=0, mode stays 0; rst=0 mid-SET_A_HR -> mode=0, ring=0.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode/sequencing controller for the alarm-clock counter chains.
// Advances time in RUN, edits one field at a time in SET modes, and rings on a time==alarm match.
module clock_mode_ctrl #(
  parameter int RING_SECS = 60,
  parameter int IDLE_SECS = 30,
  parameter int SEC_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_min,
  input  logic        min_wrap,
  input  logic        btn_c,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        alarm_sw,
  input  logic [15:0] time_hhmm,
  input  logic [15:0] alm_hhmm,
  output logic        t_min_en,
  output logic        t_hr_en,
  output logic        a_min_en,
  output logic        a_hr_en,
  output logic        up_dn,
  output logic [2:0]  mode,
  output logic        blink,
  output logic        ring
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    SET_A_HR  = 3'd3,
    SET_A_MIN = 3'd4
  } state_t;

  localparam logic [SEC_W-1:0] IDLE_LAST = SEC_W'(IDLE_SECS - 1);
  localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SECS - 1);

  state_t           state, state_n;
  logic             t_min_n, t_hr_n, a_min_n, a_hr_n, up_dn_n, blink_n, ring_n;
  logic [SEC_W-1:0] idle_cnt, idle_n;
  logic [SEC_W-1:0] ring_cnt, ring_cnt_n;
  logic             match, match_q;
  logic             any_btn, consume, ring_set, ring_clr;

  function automatic state_t step_fwd(input state_t s);
    case (s)
      SET_T_HR:  step_fwd = SET_T_MIN;
      SET_T_MIN: step_fwd = SET_A_HR;
      SET_A_HR:  step_fwd = SET_A_MIN;
      default:   step_fwd = SET_T_HR;
    endcase
  endfunction

  function automatic state_t step_rev(input state_t s);
    case (s)
      SET_T_HR:  step_rev = SET_A_MIN;
      SET_T_MIN: step_rev = SET_T_HR;
      SET_A_HR:  step_rev = SET_T_MIN;
      default:   step_rev = SET_A_HR;
    endcase
  endfunction

  assign mode    = state;
  assign match   = (time_hhmm == alm_hhmm);
  assign any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;
  // A button pressed while ringing only silences the alarm.
  assign consume = ring & any_btn;

  always_comb begin
    state_n    = state;
    t_min_n    = 1'b0;
    t_hr_n     = 1'b0;
    a_min_n    = 1'b0;
    a_hr_n     = 1'b0;
    up_dn_n    = up_dn;
    blink_n    = blink;
    idle_n     = idle_cnt;
    ring_n     = ring;
    ring_cnt_n = ring_cnt;
    ring_set   = 1'b0;
    ring_clr   = 1'b0;

    case (state)
      RUN: begin
        if (tick_min) begin
          t_min_n = 1'b1;
          t_hr_n  = min_wrap;
          up_dn_n = 1'b1;
        end
        if (btn_c && !consume) state_n = SET_T_HR;
      end
      SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN: begin
        if (!consume) begin
          if (btn_c)      state_n = RUN;
          else if (btn_r) state_n = step_fwd(state);
          else if (btn_l) state_n = step_rev(state);
          // The enable targets the field selected before any navigation this cycle.
          if (btn_u ^ btn_d) begin
            up_dn_n = btn_u;
            t_hr_n  = (state == SET_T_HR);
            t_min_n = (state == SET_T_MIN);
            a_hr_n  = (state == SET_A_HR);
            a_min_n = (state == SET_A_MIN);
          end
        end
        if (any_btn) begin
          idle_n = '0;
        end else if (tick_1hz) begin
          if (idle_cnt == IDLE_LAST) state_n = RUN;
          else                       idle_n  = idle_cnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    if (state_n == RUN) begin
      idle_n  = '0;
      blink_n = 1'b0;
    end else if (state != RUN && tick_1hz) begin
      blink_n = ~blink;
    end

    // Clear beats set when both happen in the same cycle.
    ring_set = match && !match_q && (state == RUN) && alarm_sw;
    ring_clr = any_btn || !alarm_sw || (ring && tick_1hz && ring_cnt == RING_LAST);
    if (ring_clr) begin
      ring_n     = 1'b0;
      ring_cnt_n = '0;
    end else if (ring_set) begin
      ring_n     = 1'b1;
      ring_cnt_n = '0;
    end else if (ring && tick_1hz) begin
      ring_cnt_n = ring_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      t_min_en <= 1'b0;
      t_hr_en  <= 1'b0;
      a_min_en <= 1'b0;
      a_hr_en  <= 1'b0;
      up_dn    <= 1'b1;
      blink    <= 1'b0;
      ring     <= 1'b0;
      idle_cnt <= '0;
      ring_cnt <= '0;
      match_q  <= 1'b0;
    end else begin
      state    <= state_n;
      t_min_en <= t_min_n;
      t_hr_en  <= t_hr_n;
      a_min_en <= a_min_n;
      a_hr_en  <= a_hr_n;
      up_dn    <= up_dn_n;
      blink    <= blink_n;
      ring     <= ring_n;
      idle_cnt <= idle_n;
      ring_cnt <= ring_cnt_n;
      match_q  <= match;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed, table-driven bench for clock_mode_ctrl.
// Outputs are compared as one packed word {mode, t_min_en, t_hr_en, a_min_en, a_hr_en, up_dn, blink, ring}.
module tb_clock_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz, tick_min, min_wrap;
  logic        btn_c, btn_l, btn_r, btn_u, btn_d;
  logic        alarm_sw;
  logic [15:0] time_hhmm, alm_hhmm;
  logic        t_min_en, t_hr_en, a_min_en, a_hr_en, up_dn, blink, ring;
  logic [2:0]  mode;

  int assertCount = 0;
  int failCount   = 0;

  // stim = {btn_c, btn_l, btn_r, btn_u, btn_d, tick_min, min_wrap}
  // enUp = {t_min_en, t_hr_en, a_min_en, a_hr_en, up_dn}
  typedef struct {
    logic [6:0] stim;
    logic [2:0] expMode;
    logic [4:0] expEnUp;
  } vec_t;

  vec_t vecs[23];

  clock_mode_ctrl #(.RING_SECS(60), .IDLE_SECS(30), .SEC_W(6)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_min(tick_min), .min_wrap(min_wrap),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .alarm_sw(alarm_sw), .time_hhmm(time_hhmm), .alm_hhmm(alm_hhmm),
    .t_min_en(t_min_en), .t_hr_en(t_hr_en), .a_min_en(a_min_en), .a_hr_en(a_hr_en),
    .up_dn(up_dn), .mode(mode), .blink(blink), .ring(ring)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [6:0] s, input logic [2:0] m, input logic [4:0] e);
    vec_t v;
    v.stim = s;
    v.expMode = m;
    v.expEnUp = e;
    return v;
  endfunction

  function automatic logic [9:0] outv(input logic [2:0] m, input logic [4:0] e, input logic bl,
                                      input logic rg);
    return {m, e, bl, rg};
  endfunction

  task automatic applyStimulus(input logic [6:0] stim, input logic tick);
    @(negedge clk);
    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_min, min_wrap} = stim;
    tick_1hz = tick;
    @(posedge clk);
    #1;
    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_min, min_wrap} = 7'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic pulseTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(7'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] expected);
    logic [9:0] actual;
    actual = {mode, t_min_en, t_hr_en, a_min_en, a_hr_en, up_dn, blink, ring};
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b (mode,tmin,thr,amin,ahr,up,blink,ring)",
               name, actual, expected);
    end
  endtask

  initial begin
    vecs[0]  = mkVec(7'b0000011, 3'd0, 5'b11001);
    vecs[1]  = mkVec(7'b0000010, 3'd0, 5'b10001);
    vecs[2]  = mkVec(7'b0000000, 3'd0, 5'b00001);
    vecs[3]  = mkVec(7'b1000000, 3'd1, 5'b00001);
    vecs[4]  = mkVec(7'b0010000, 3'd2, 5'b00001);
    vecs[5]  = mkVec(7'b0010000, 3'd3, 5'b00001);
    vecs[6]  = mkVec(7'b0010000, 3'd4, 5'b00001);
    vecs[7]  = mkVec(7'b0010000, 3'd1, 5'b00001);
    vecs[8]  = mkVec(7'b0100000, 3'd4, 5'b00001);
    vecs[9]  = mkVec(7'b0000100, 3'd4, 5'b00100);
    vecs[10] = mkVec(7'b0001000, 3'd4, 5'b00101);
    vecs[11] = mkVec(7'b0001100, 3'd4, 5'b00001);
    vecs[12] = mkVec(7'b0100100, 3'd3, 5'b00100);
    vecs[13] = mkVec(7'b0001000, 3'd3, 5'b00011);
    vecs[14] = mkVec(7'b0110000, 3'd4, 5'b00001);
    vecs[15] = mkVec(7'b0010000, 3'd1, 5'b00001);
    vecs[16] = mkVec(7'b0000100, 3'd1, 5'b01000);
    vecs[17] = mkVec(7'b0010000, 3'd2, 5'b00000);
    vecs[18] = mkVec(7'b0001000, 3'd2, 5'b10001);
    vecs[19] = mkVec(7'b0000011, 3'd2, 5'b00001);
    vecs[20] = mkVec(7'b1010000, 3'd0, 5'b00001);
    vecs[21] = mkVec(7'b1000000, 3'd1, 5'b00001);
    vecs[22] = mkVec(7'b0010000, 3'd2, 5'b00001);

    // Reset held two cycles with every input active.
    rst = 1'b0;
    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_min, min_wrap} = 7'h7F;
    tick_1hz = 1'b1;
    alarm_sw = 1'b1;
    time_hhmm = 16'h0700;
    alm_hhmm  = 16'h0700;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_min, min_wrap} = 7'b0;
    tick_1hz  = 1'b0;
    alarm_sw  = 1'b0;
    time_hhmm = 16'h0000;
    alm_hhmm  = 16'h1234;
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].stim, 1'b0);
      checkOutput($sformatf("vec%0d", i), outv(vecs[i].expMode, vecs[i].expEnUp, 1'b0, 1'b0));
    end

    // Idle timeout from SET_T_MIN: 29 ticks stay, 30th returns to RUN.
    pulseTicks(29);
    checkOutput("idle29", outv(3'd2, 5'b00001, 1'b1, 1'b0));
    pulseTicks(1);
    checkOutput("idle30", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // A button mid-count restarts the idle timer.
    applyStimulus(7'b1000000, 1'b0);
    pulseTicks(20);
    applyStimulus(7'b0001000, 1'b0);
    checkOutput("idle_btn_up", outv(3'd1, 5'b01001, 1'b0, 1'b0));
    pulseTicks(29);
    checkOutput("idle_restart29", outv(3'd1, 5'b00001, 1'b1, 1'b0));
    pulseTicks(1);
    checkOutput("idle_restart30", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // Alarm match rising edge rings; 60 ticks silence it; no retrigger while match stays high.
    alarm_sw  = 1'b1;
    alm_hhmm  = 16'h0700;
    time_hhmm = 16'h0659;
    applyStimulus(7'b0, 1'b0);
    time_hhmm = 16'h0700;
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_set", outv(3'd0, 5'b00001, 1'b0, 1'b1));
    pulseTicks(59);
    checkOutput("ring_59", outv(3'd0, 5'b00001, 1'b0, 1'b1));
    pulseTicks(1);
    checkOutput("ring_60", outv(3'd0, 5'b00001, 1'b0, 1'b0));
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_no_retrig", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // Button clears ring and is consumed (no mode change).
    time_hhmm = 16'h0659;
    applyStimulus(7'b0, 1'b0);
    time_hhmm = 16'h0700;
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_set2", outv(3'd0, 5'b00001, 1'b0, 1'b1));
    applyStimulus(7'b1000000, 1'b0);
    checkOutput("ring_btn_clr", outv(3'd0, 5'b00001, 1'b0, 1'b0));
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_btn_mode", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // alarm_sw low clears ring.
    time_hhmm = 16'h0659;
    applyStimulus(7'b0, 1'b0);
    time_hhmm = 16'h0700;
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_set3", outv(3'd0, 5'b00001, 1'b0, 1'b1));
    alarm_sw = 1'b0;
    applyStimulus(7'b0, 1'b0);
    checkOutput("ring_sw_clr", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // Set and clear in the same cycle: clear wins.
    alarm_sw  = 1'b1;
    time_hhmm = 16'h0659;
    applyStimulus(7'b0, 1'b0);
    time_hhmm = 16'h0700;
    applyStimulus(7'b0100000, 1'b0);
    checkOutput("ring_set_clr", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // Match rising during SET does not ring on return to RUN.
    time_hhmm = 16'h0659;
    applyStimulus(7'b1000000, 1'b0);
    time_hhmm = 16'h0700;
    applyStimulus(7'b0, 1'b0);
    checkOutput("set_match", outv(3'd1, 5'b00001, 1'b0, 1'b0));
    applyStimulus(7'b1000000, 1'b0);
    applyStimulus(7'b0, 1'b0);
    checkOutput("set_exit_no_ring", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    // Reset in the middle of SET_A_HR with blink high and up_dn low.
    applyStimulus(7'b1000000, 1'b0);
    applyStimulus(7'b0010000, 1'b0);
    applyStimulus(7'b0010000, 1'b0);
    applyStimulus(7'b0, 1'b1);
    applyStimulus(7'b0000100, 1'b0);
    checkOutput("pre_reset", outv(3'd3, 5'b00010, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("mid_reset", outv(3'd0, 5'b00001, 1'b0, 1'b0));

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
